fpnew_req_scheduler: RTL and testbench
======================================

// Module: fpnew_req_scheduler
// PURPOSE
// Shares one fpnew_top instance (RV16F, ISA_PIPE) among NumReq requesters, e.g. multiple UVM agents or cores.
// Round-robin arbitration of issue requests; requester index carried in the FPU tag; each result routed back
// to its originator. Credit counter bounds in-flight ops; FSM sequences flush of FPU and scheduler state.
// Sits directly in front of fpnew_top: drives operands_i/op_i/rnd_mode_i/op_mod_i/tag_i/flush_i, consumes outputs.
// PARAMETERS
// NumReq         4   number of requesters (>=2)
// Width          16  FP operand/result width, equals fpnew_top WIDTH
// MaxOutstanding 4   max issued-but-unreturned ops (1..15)
// IdxW           $clog2(NumReq) (localparam) requester-index / tag width
// PORTS
// clk_i          in   1                 clock, all logic rising-edge
// rst_ni         in   1                 reset, asynchronous, active-low
// flush_i        in   1                 abort all in-flight work
// req_valid_i    in   NumReq            per-requester issue valid
// req_ready_o    out  NumReq            per-requester issue ready (one-hot or zero)
// req_operands_i in   NumReq*3*Width    operands per requester
// req_op_i       in   NumReq*4          fpnew_pkg::operation_e per requester
// req_op_mod_i   in   NumReq            op modifier per requester
// req_rnd_i      in   NumReq*3          fpnew_pkg::roundmode_e per requester
// rsp_valid_o    out  NumReq            per-requester result valid (one-hot or zero)
// rsp_ready_i    in   NumReq            per-requester result ready
// rsp_result_o   out  Width             result, shared bus, qualified by rsp_valid_o
// rsp_status_o   out  5                 fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
// fpu_*_o        out  -                 operands(3*Width)/op(4)/op_mod(1)/rnd(3)/tag(IdxW)/in_valid/out_ready/flush
// fpu_*_i        in   -                 in_ready/result(Width)/status(5)/tag(IdxW)/out_valid
// busy_o         out  1                 credit count!=0 or FSM not IDLE
// BEHAVIOUR
// Reset: all outputs 0; rr_ptr=0; credits=0; FSM=IDLE; lock=0.
// FSM states: IDLE (credits==0), RUN (credits>0), FLUSH (1 cycle), DRAIN.
//  IDLE->RUN on issue handshake; RUN->IDLE when credits returns to 0; any->FLUSH on flush_i;
//  FLUSH->DRAIN; DRAIN->IDLE when fpu_out_valid_i==0 for 2 consecutive cycles.
// Issue (IDLE/RUN only): grant = first req_valid_i at/after rr_ptr (wrap NumReq-1->0).
//  fpu_in_valid_o=|req_valid_i & credits<MaxOutstanding; fpu_tag_o=grant index; fields muxed from grant.
//  req_ready_o[g]=fpu_in_ready_i & fpu_in_valid_o (combinational, zero added latency).
//  Stall (valid & !in_ready): grant locked, fpu_* inputs held stable until handshake; rr_ptr frozen.
//  On handshake: rr_ptr<=g+1 mod NumReq; credits++.
// Full: credits==MaxOutstanding -> fpu_in_valid_o=0, req_ready_o=0.
// Return: rsp_valid_o[fpu_tag_i]=fpu_out_valid_i; fpu_out_ready_o=rsp_ready_i[fpu_tag_i];
//  result/status passed combinationally; handshake -> credits--. Issue+return same cycle -> credits unchanged.
//  Out-of-range fpu_tag_i (NumReq not power of 2): result discarded, fpu_out_ready_o=1, credits--.
// Flush: FLUSH asserts fpu_flush_o for exactly 1 cycle, credits<=0, lock<=0; req_ready_o=0 and
//  rsp_valid_o=0 throughout FLUSH/DRAIN; fpu_out_ready_o=1 in DRAIN to sink stragglers.
//  flush_i during FLUSH/DRAIN restarts FLUSH. rr_ptr preserved across flush.
// Reset mid-operation: asynchronous return to reset state; no response delivered for in-flight ops.
// Credit underflow (return with credits==0) is a protocol error: assertion fires, counter saturates at 0.
// TESTING
// 1 Single op: req0 MUL 16'h3C00*16'h4000, in_ready=1 -> tag 0 issued same cycle; rsp_valid_o=4'b0001, result 16'h4000.
// 2 Fairness: all 4 req_valid_i held 8 cycles, in_ready=1 -> grant order 0,1,2,3,0,1,2,3.
// 3 Backpressure: in_ready=0 3 cycles with req1,req2 valid -> fpu_tag_o stays 1, operands stable; then 1 issues, next 2.
// 4 Full: out_ready held low, MaxOutstanding=4 -> 5th op blocked (req_ready_o=0) until one response handshakes.
// 5 Simultaneous issue+return at credits=2 -> credits remains 2; routing: tag 3 result -> rsp_valid_o=4'b1000 only.
// 6 Flush with 3 in flight -> fpu_flush_o 1-cycle pulse, no rsp_valid_o, busy_o drops after DRAIN, next op issues normally.

Source files
------------

// File: rtl/fpnew_req_scheduler.sv
// Round-robin request scheduler that shares one fpnew_top among NumReq requesters.
// Requester index rides in the FPU tag; a credit counter bounds in-flight ops; an FSM sequences flushes.
module fpnew_req_scheduler #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 16,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW          = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*3*Width-1:0]   req_operands_i,
  input  logic [NumReq*4-1:0]         req_op_i,
  input  logic [NumReq-1:0]           req_op_mod_i,
  input  logic [NumReq*3-1:0]         req_rnd_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [Width-1:0]            rsp_result_o,
  output logic [4:0]                  rsp_status_o,
  output logic [3*Width-1:0]          fpu_operands_o,
  output logic [3:0]                  fpu_op_o,
  output logic                        fpu_op_mod_o,
  output logic [2:0]                  fpu_rnd_o,
  output logic [IdxW-1:0]             fpu_tag_o,
  output logic                        fpu_in_valid_o,
  output logic                        fpu_out_ready_o,
  output logic                        fpu_flush_o,
  input  logic                        fpu_in_ready_i,
  input  logic [Width-1:0]            fpu_result_i,
  input  logic [4:0]                  fpu_status_i,
  input  logic [IdxW-1:0]             fpu_tag_i,
  input  logic                        fpu_out_valid_i,
  output logic                        busy_o
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] credits_q, credits_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            drain_cnt_q, drain_cnt_d;

  logic [IdxW-1:0] grant;
  logic            any_valid;
  logic            full;
  logic            issue_en;
  logic            issue_hs;
  logic            ret_en;
  logic            ret_hs;
  logic            tag_ok;
  logic            sel_ready;

  // Arbiter: a stalled grant stays locked so the FPU sees stable inputs until it accepts.
  always_comb begin : arbiter
    int unsigned off;
    int unsigned best;
    grant     = rr_ptr_q;
    any_valid = 1'b0;
    best      = NumReq;
    off       = 0;
    for (int i = 0; i < NumReq; i++) begin
      if (lock_q) begin
        if (lock_idx_q == IdxW'(i)) begin
          grant     = lock_idx_q;
          any_valid = req_valid_i[i];
        end
      end else begin
        off = (i + NumReq - int'(rr_ptr_q)) % NumReq;
        if (req_valid_i[i] && (off < best)) begin
          best      = off;
          grant     = IdxW'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

  assign full           = (credits_q >= CntW'(MaxOutstanding));
  assign issue_en       = ((state_q == IDLE) || (state_q == RUN)) && !flush_i;
  assign fpu_in_valid_o = issue_en && any_valid && !full;
  assign issue_hs       = fpu_in_valid_o && fpu_in_ready_i;
  assign fpu_tag_o      = fpu_in_valid_o ? grant : '0;
  assign fpu_flush_o    = (state_q == FLUSH);

  always_comb begin
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_op_mod_o   = 1'b0;
    fpu_rnd_o      = '0;
    req_ready_o    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (fpu_in_valid_o && (grant == IdxW'(i))) begin
        fpu_operands_o = req_operands_i[i*3*Width +: 3*Width];
        fpu_op_o       = req_op_i[i*4 +: 4];
        fpu_op_mod_o   = req_op_mod_i[i];
        fpu_rnd_o      = req_rnd_i[i*3 +: 3];
        req_ready_o[i] = fpu_in_ready_i;
      end
    end
  end

  // Return path: results with a tag outside the requester range are sunk without delivery.
  assign ret_en = (state_q == IDLE) || (state_q == RUN);

  always_comb begin
    tag_ok      = 1'b0;
    sel_ready   = 1'b0;
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (fpu_tag_i == IdxW'(i)) begin
        tag_ok         = 1'b1;
        sel_ready      = rsp_ready_i[i];
        rsp_valid_o[i] = ret_en && fpu_out_valid_i;
      end
    end
  end

  assign fpu_out_ready_o = ret_en ? (tag_ok ? sel_ready : 1'b1) : 1'b1;
  assign ret_hs          = ret_en && fpu_out_valid_i && fpu_out_ready_o;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign busy_o          = (credits_q != '0) || (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    credits_d   = credits_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (issue_hs && !ret_hs) begin
          credits_d = credits_q + 1'b1;
        end else if (ret_hs && !issue_hs) begin
          credits_d = (credits_q == '0) ? '0 : credits_q - 1'b1;
        end
        if (issue_hs) begin
          rr_ptr_d = (grant == IdxW'(NumReq-1)) ? '0 : grant + 1'b1;
          lock_d   = 1'b0;
        end else begin
          lock_d     = fpu_in_valid_o;
          lock_idx_d = grant;
        end
        state_d = (credits_d != '0) ? RUN : IDLE;
      end
      FLUSH: begin
        credits_d   = '0;
        lock_d      = 1'b0;
        drain_cnt_d = 1'b0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (fpu_out_valid_i) begin
          drain_cnt_d = 1'b0;
        end else if (drain_cnt_q) begin
          drain_cnt_d = 1'b0;
          state_d     = IDLE;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      credits_q   <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  credit_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ret_hs |-> (credits_q != '0));

endmodule

// File: tb/tb_fpnew_req_scheduler.sv
// Directed bench for fpnew_req_scheduler: vector table for arbitration/credits/routing,
// hand sequences for backpressure locking and the flush/drain sequence.
module tb_fpnew_req_scheduler;

  localparam int NumReq = 4;
  localparam int Width  = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NumReq-1:0]         req_valid;
  logic [NumReq-1:0]         req_ready;
  logic [NumReq*3*Width-1:0] req_operands;
  logic [NumReq*4-1:0]       req_op;
  logic [NumReq-1:0]         req_op_mod;
  logic [NumReq*3-1:0]       req_rnd;
  logic [NumReq-1:0]         rsp_valid;
  logic [NumReq-1:0]         rsp_ready;
  logic [Width-1:0]          rsp_result;
  logic [4:0]                rsp_status;
  logic [3*Width-1:0]        fpu_operands;
  logic [3:0]                fpu_op;
  logic                      fpu_op_mod;
  logic [2:0]                fpu_rnd;
  logic [1:0]                fpu_tag_o;
  logic                      fpu_in_valid;
  logic                      fpu_out_ready;
  logic                      fpu_flush;
  logic                      fpu_in_ready;
  logic [Width-1:0]          fpu_result;
  logic [4:0]                fpu_status;
  logic [1:0]                fpu_tag_i;
  logic                      fpu_out_valid;
  logic                      busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpnew_req_scheduler #(.NumReq(4), .Width(16), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
    .req_rnd_i(req_rnd), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
    .fpu_rnd_o(fpu_rnd), .fpu_tag_o(fpu_tag_o), .fpu_in_valid_o(fpu_in_valid),
    .fpu_out_ready_o(fpu_out_ready), .fpu_flush_o(fpu_flush),
    .fpu_in_ready_i(fpu_in_ready), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
    .fpu_tag_i(fpu_tag_i), .fpu_out_valid_i(fpu_out_valid), .busy_o(busy)
  );

  function automatic logic [47:0] opsf(input int i);
    return {16'(i * 4096), 16'(16'h4000 + i), 16'(16'h3C00 + i)};
  endfunction

  function automatic logic [3:0] opexp(input int i);
    return (i == 0) ? 4'd3 : 4'(i);
  endfunction

  typedef struct {
    logic [3:0] rv;  logic ir;  logic ov;  logic [1:0] ti;  logic [3:0] rr;
    logic [3:0] e_rdy; logic e_iv; logic [1:0] e_tag; logic [3:0] e_rsp; logic e_ord; logic e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] rv, input logic ir, input logic ov,
                              input logic [1:0] ti, input logic [3:0] rr,
                              input logic [3:0] e_rdy, input logic e_iv, input logic [1:0] e_tag,
                              input logic [3:0] e_rsp, input logic e_ord, input logic e_busy);
    vec_t v;
    v.rv = rv; v.ir = ir; v.ov = ov; v.ti = ti; v.rr = rr;
    v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_tag = e_tag; v.e_rsp = e_rsp; v.e_ord = e_ord; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] rv, input logic ir, input logic ov,
                     input logic [1:0] ti, input logic [3:0] rr);
    req_valid = rv; fpu_in_ready = ir; fpu_out_valid = ov; fpu_tag_i = ti; rsp_ready = rr;
    #3;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req_valid = '0; rsp_ready = '0; fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_tag_i = '0;
    fpu_result = 16'h4000; fpu_status = 5'b00001;
    req_operands = {opsf(3), opsf(2), opsf(1), opsf(0)};
    req_op       = {4'd3, 4'd2, 4'd1, 4'd3};
    req_op_mod   = 4'b1010;
    req_rnd      = {3'd3, 3'd2, 3'd1, 3'd0};

    // Fairness, single op, issue+return at credits=2, full, then drain back to idle
    tbl.push_back(mk(4'b1111,1,0,0,4'b1111, 4'b0001,1,0,4'b0000,1,0));
    tbl.push_back(mk(4'b1111,1,1,0,4'b1111, 4'b0010,1,1,4'b0001,1,1));
    tbl.push_back(mk(4'b1111,1,1,1,4'b1111, 4'b0100,1,2,4'b0010,1,1));
    tbl.push_back(mk(4'b1111,1,1,2,4'b1111, 4'b1000,1,3,4'b0100,1,1));
    tbl.push_back(mk(4'b1111,1,1,3,4'b1111, 4'b0001,1,0,4'b1000,1,1));
    tbl.push_back(mk(4'b1111,1,1,0,4'b1111, 4'b0010,1,1,4'b0001,1,1));
    tbl.push_back(mk(4'b1111,1,1,1,4'b1111, 4'b0100,1,2,4'b0010,1,1));
    tbl.push_back(mk(4'b1111,1,1,2,4'b1111, 4'b1000,1,3,4'b0100,1,1));
    tbl.push_back(mk(4'b0000,1,1,3,4'b1111, 4'b0000,0,0,4'b1000,1,1));
    tbl.push_back(mk(4'b0000,0,0,0,4'b0000, 4'b0000,0,0,4'b0000,0,0));
    tbl.push_back(mk(4'b0001,1,0,0,4'b1111, 4'b0001,1,0,4'b0000,1,0));
    tbl.push_back(mk(4'b0000,1,1,0,4'b0001, 4'b0000,0,0,4'b0001,1,1));
    tbl.push_back(mk(4'b0100,1,0,0,4'b1111, 4'b0100,1,2,4'b0000,1,0));
    tbl.push_back(mk(4'b1000,1,0,0,4'b1111, 4'b1000,1,3,4'b0000,1,1));
    tbl.push_back(mk(4'b0001,1,1,3,4'b1111, 4'b0001,1,0,4'b1000,1,1));
    tbl.push_back(mk(4'b0010,1,0,0,4'b0000, 4'b0010,1,1,4'b0000,0,1));
    tbl.push_back(mk(4'b0100,1,0,0,4'b0000, 4'b0100,1,2,4'b0000,0,1));
    tbl.push_back(mk(4'b1111,1,0,0,4'b0000, 4'b0000,0,0,4'b0000,0,1));
    tbl.push_back(mk(4'b1111,1,1,2,4'b0000, 4'b0000,0,0,4'b0100,0,1));
    tbl.push_back(mk(4'b1111,1,1,2,4'b0100, 4'b0000,0,0,4'b0100,1,1));
    tbl.push_back(mk(4'b1111,1,0,0,4'b0000, 4'b1000,1,3,4'b0000,0,1));
    tbl.push_back(mk(4'b0000,0,1,0,4'b1111, 4'b0000,0,0,4'b0001,1,1));
    tbl.push_back(mk(4'b0000,0,1,1,4'b1111, 4'b0000,0,0,4'b0010,1,1));
    tbl.push_back(mk(4'b0000,0,1,2,4'b1111, 4'b0000,0,0,4'b0100,1,1));
    tbl.push_back(mk(4'b0000,0,1,3,4'b1111, 4'b0000,0,0,4'b1000,1,1));
    tbl.push_back(mk(4'b0000,0,0,0,4'b0000, 4'b0000,0,0,4'b0000,0,0));

    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_in_valid", fpu_in_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush", fpu_flush, 0);
    chk("rst_out_ready", fpu_out_ready, 0);
    chk("rst_operands", fpu_operands, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].rv, tbl[i].ir, tbl[i].ov, tbl[i].ti, tbl[i].rr);
      chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_in_valid", i), fpu_in_valid, tbl[i].e_iv);
      chk($sformatf("v%0d_tag", i), fpu_tag_o, tbl[i].e_tag);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].e_rsp);
      chk($sformatf("v%0d_out_ready", i), fpu_out_ready, tbl[i].e_ord);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d_operands", i), fpu_operands, opsf(int'(tbl[i].e_tag)));
        chk($sformatf("v%0d_op", i), fpu_op, opexp(int'(tbl[i].e_tag)));
      end
      if (tbl[i].e_rsp != 4'b0000) begin
        chk($sformatf("v%0d_result", i), rsp_result, 16'h4000);
        chk($sformatf("v%0d_status", i), rsp_status, 5'b00001);
      end
      step();
    end

    // Backpressure: grant 1 locked while req0 appears, then 1 issues, then 2
    for (int c = 0; c < 3; c++) begin
      drv((c == 0) ? 4'b0110 : 4'b0111, 0, 0, 0, 4'b1111);
      chk($sformatf("bp%0d_tag", c), fpu_tag_o, 1);
      chk($sformatf("bp%0d_in_valid", c), fpu_in_valid, 1);
      chk($sformatf("bp%0d_req_ready", c), req_ready, 0);
      chk($sformatf("bp%0d_operands", c), fpu_operands, opsf(1));
      step();
    end
    drv(4'b0111, 1, 0, 0, 4'b1111);
    chk("bp_issue1", req_ready, 4'b0010);
    step();
    drv(4'b0110, 1, 0, 0, 4'b1111);
    chk("bp_issue2", req_ready, 4'b0100);
    chk("bp_issue2_tag", fpu_tag_o, 2);
    step();
    drv(4'b0000, 0, 1, 1, 4'b1111);
    chk("bp_ret1", rsp_valid, 4'b0010);
    step();
    drv(4'b0000, 0, 1, 2, 4'b1111);
    chk("bp_ret2", rsp_valid, 4'b0100);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("bp_idle_busy", busy, 0);

    // Flush with three ops in flight (rr_ptr is 3 here)
    drv(4'b1111, 1, 0, 0, 4'b0000);
    chk("fl_issue_a", req_ready, 4'b1000);
    step();
    drv(4'b1111, 1, 0, 0, 4'b0000);
    chk("fl_issue_b", req_ready, 4'b0001);
    step();
    drv(4'b1111, 1, 0, 0, 4'b0000);
    chk("fl_issue_c", req_ready, 4'b0010);
    step();
    flush = 1'b1;
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("fl_req_flush_o", fpu_flush, 0);
    step();
    flush = 1'b0;
    drv(4'b1111, 1, 1, 0, 4'b1111);
    chk("fl_flush_o", fpu_flush, 1);
    chk("fl_req_ready", req_ready, 0);
    chk("fl_in_valid", fpu_in_valid, 0);
    chk("fl_rsp_valid", rsp_valid, 0);
    chk("fl_busy", busy, 1);
    step();
    drv(4'b1111, 1, 1, 1, 4'b0000);
    chk("dr1_flush_o", fpu_flush, 0);
    chk("dr1_rsp_valid", rsp_valid, 0);
    chk("dr1_out_ready", fpu_out_ready, 1);
    chk("dr1_req_ready", req_ready, 0);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    step();
    drv(4'b0000, 0, 1, 2, 4'b0000);
    chk("dr3_rsp_valid", rsp_valid, 0);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("dr4_busy", busy, 1);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("dr5_busy", busy, 1);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("post_flush_busy", busy, 0);
    step();
    drv(4'b0001, 1, 0, 0, 4'b1111);
    chk("post_flush_issue", req_ready, 4'b0001);
    chk("post_flush_tag", fpu_tag_o, 0);
    step();
    drv(4'b0000, 0, 1, 0, 4'b1111);
    chk("post_flush_ret", rsp_valid, 4'b0001);
    step();
    drv(4'b0000, 0, 0, 0, 4'b0000);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
